// File: rtl/trigger_scheduler_pkg.sv
// Shared types for the trigger scheduler: fill-type encoding, FSM states, defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package trigger_scheduler_pkg;

  // 2-bit fill type carried with every trigger
  typedef logic [1:0] fill_t;

  localparam fill_t FILL_TYPE_0 = 2'd0;
  localparam fill_t FILL_TYPE_1 = 2'd1;
  localparam fill_t FILL_TYPE_2 = 2'd2;
  localparam fill_t FILL_TYPE_3 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2,
    ST_HOLDOFF   = 2'd3
  } state_t;

  localparam int DEFAULT_CNT_W = 16;

endpackage

// File: rtl/trigger_scheduler_if.sv
// Trigger bus: raw trigger pulses in, issued triggers out to the trigger manager.
// Latency: n/a (wiring only).
// Backpressure: none on ext_trig (overflow is dropped); tm_done closes each issued fill.
// Ports: ext_trig/ext_fill_type (trigger source), tm_trigger/tm_fill_type/tm_done
// (trigger manager). master = scheduler side, slave = source/manager side.
interface trigger_scheduler_if;
  logic                        ext_trig;
  trigger_scheduler_pkg::fill_t ext_fill_type;
  logic                        tm_trigger;
  trigger_scheduler_pkg::fill_t tm_fill_type;
  logic                        tm_done;

  modport master (
    input  ext_trig, ext_fill_type, tm_done,
    output tm_trigger, tm_fill_type
  );

  modport slave (
    output ext_trig, ext_fill_type, tm_done,
    input  tm_trigger, tm_fill_type
  );
endinterface

// File: rtl/trigger_scheduler_fifo.sv
// trig_fill_fifo: DEPTH-entry synchronous FIFO of fill types with registered occupancy.
// Latency: push visible in count/head the cycle after; head is read combinationally.
// Backpressure: push while full and pop while empty are ignored; caller checks count.
// Ports: clk, reset_n, push/push_dat, pop, head_dat, count.
module trig_fill_fifo
  import trigger_scheduler_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  fill_t                    push_dat,
  input  logic                     pop,
  output fill_t                    head_dat,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  fill_t          mem_q [DEPTH];
  fill_t          mem_d [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           push_ok, pop_ok;

  always_comb begin
    push_ok  = push && (count_q != (AW+1)'(DEPTH));
    pop_ok   = pop && (count_q != '0);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    // DEPTH is a power of two, so pointers wrap naturally
    count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign count    = count_q;

endmodule

// File: rtl/trigger_scheduler.sv
// Trigger scheduler: queues tagged trigger pulses and issues them one at a time to the
// trigger manager, waiting for tm_done and a programmable holdoff between issues.
// Latency: ext_trig in cycle N (idle, empty, enabled) -> tm_trigger in cycle N+2.
// Backpressure: none upstream; triggers arriving with the queue full are dropped and counted.
// Ports: clk, reset_n, enable, holdoff_cycles, clear_stats, bus (trigger_scheduler_if.master),
// busy, pending_count, drop_count, timeout_err.
// Optional: define TRIG_TIMEOUT_EN to add a WAIT_DONE watchdog of TIMEOUT_CYC cycles.
module trigger_scheduler
  import trigger_scheduler_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic [15:0]                holdoff_cycles,
  input  logic                       clear_stats,
  trigger_scheduler_if.master        bus,
  output logic                       busy,
  output logic [$clog2(DEPTH):0]     pending_count,
  output logic [CNT_W-1:0]           drop_count,
  output logic                       timeout_err
);
  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("trigger_scheduler: bad DEPTH or TIMEOUT_CYC");
  end

  state_t            state_q, state_d;
  fill_t             fill_q, fill_d;
  logic [15:0]       hold_q, hold_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  drop_q, drop_d;

  logic              push_req, fifo_full, fifo_push, fifo_pop, drop;
  fill_t             head;
  logic [AW:0]       count;
  logic              wd_expire;

  trig_fill_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .push_dat (bus.ext_fill_type),
    .pop      (fifo_pop),
    .head_dat (head),
    .count    (count)
  );

  // Full is taken from the registered count, so a same-cycle pop never rescues a push.
  assign push_req  = bus.ext_trig && enable;
  assign fifo_full = (count == (AW+1)'(DEPTH));
  assign fifo_push = push_req && !fifo_full;
  assign drop      = push_req && fifo_full;

  always_comb begin
    state_d  = state_q;
    fill_d   = fill_q;
    hold_d   = hold_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable && (count != '0)) begin
          state_d = ST_ISSUE;
          // Head is stable until the ISSUE pop, so capture it now to have
          // tm_fill_type valid alongside the tm_trigger pulse.
          fill_d  = head;
        end
      end
      ST_ISSUE: begin
        fifo_pop = 1'b1;
        state_d  = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (bus.tm_done || wd_expire) begin
          if (holdoff_cycles == 16'd0) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_HOLDOFF;
            hold_d  = holdoff_cycles;
          end
        end
      end
      ST_HOLDOFF: begin
        if (hold_q <= 16'd1) begin
          state_d = ST_IDLE;
        end else begin
          hold_d = hold_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);

    if (clear_stats) begin
      drop_d = '0;
    end else if (drop && (drop_q != '1)) begin
      drop_d = drop_q + CNT_W'(1);
    end else begin
      drop_d = drop_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      fill_q  <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
      drop_q  <= drop_d;
    end
  end

`ifdef TRIG_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_err_q, to_err_d;

  // wd_q holds (cycles already spent in WAIT_DONE); expiry fires in the
  // TIMEOUT_CYC-th cycle unless tm_done arrives in that same cycle.
  assign wd_expire = (state_q == ST_WAIT_DONE) && !bus.tm_done &&
                     (wd_q == WD_W'(TIMEOUT_CYC - 1));

  always_comb begin
    wd_d = '0;
    if ((state_q == ST_WAIT_DONE) && (state_d == ST_WAIT_DONE)) begin
      wd_d = wd_q + WD_W'(1);
    end
    if (clear_stats) begin
      to_err_d = 1'b0;
    end else begin
      to_err_d = to_err_q || wd_expire;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q     <= '0;
      to_err_q <= 1'b0;
    end else begin
      wd_q     <= wd_d;
      to_err_q <= to_err_d;
    end
  end

  assign timeout_err = to_err_q;
`else
  assign wd_expire   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign bus.tm_trigger   = (state_q == ST_ISSUE);
  assign bus.tm_fill_type = fill_q;
  assign busy             = busy_q;
  assign pending_count    = count;
  assign drop_count       = drop_q;

endmodule

// File: doc/trigger_scheduler.md
Name: trigger_scheduler

Overview:
Front-end sequencer for the trigger manager. Accepts raw trigger pulses tagged with a fill type, buffers them in a small pending queue, and issues them to the trigger manager one at a time. It waits for each fill to complete (trigger number stored) and enforces a programmable holdoff before the next issue. Triggers arriving with the queue full are counted as dropped.

Parameters:
DEPTH, 4, pending-queue entries; power of 2, 2..16
CNT_W, 16, width of drop counter
TIMEOUT_CYC, 1000000, WAIT_DONE watchdog limit in clk cycles (used only with TRIG_TIMEOUT_EN)

Ports:
clk  in  1  user clock; single clock domain
reset_n  in  1  asynchronous, active-low reset
enable  in  1  scheduler enable (level)
ext_trig  in  1  single-cycle trigger pulse
ext_fill_type  in  2  fill type, qualified by ext_trig
holdoff_cycles  in  16  idle gap after each completion; quasi-static
clear_stats  in  1  pulse; clears drop_count and timeout_err
tm_trigger  out  1  one-cycle trigger pulse to the trigger manager
tm_fill_type  out  2  fill type; held stable from issue until completion
tm_done  in  1  fill complete: trigger manager FIFO valid AND ready
busy  out  1  high in ISSUE, WAIT_DONE and HOLDOFF
pending_count  out  log2(DEPTH)+1  queue occupancy
drop_count  out  CNT_W  saturating count of dropped triggers
timeout_err  out  1  sticky watchdog flag (0 without TRIG_TIMEOUT_EN)

Behaviour:
- Reset (async assert, sync release): state IDLE, queue empty, all outputs 0.
- Queue: FIFO of 2-bit fill types.
  - On ext_trig with enable=1: push if pending_count<DEPTH, otherwise drop and increment drop_count.
  - Full is evaluated before any same-cycle pop, so a trigger arriving at full with a concurrent pop is still dropped.
  - ext_trig with enable=0 is ignored: not queued, not counted.
- drop_count saturates at all-ones.
- clear_stats zeroes drop_count and timeout_err. If clear_stats and a drop occur in the same cycle, clear wins.
- FSM states: IDLE, ISSUE, WAIT_DONE, HOLDOFF.
  - IDLE: if enable && queue non-empty, go to ISSUE.
  - ISSUE (1 cycle): pop head into tm_fill_type register; tm_trigger=1 this cycle only; go to WAIT_DONE.
  - WAIT_DONE: tm_trigger=0; tm_fill_type held; on tm_done go to HOLDOFF (or directly to IDLE if holdoff_cycles==0).
  - HOLDOFF: load counter with holdoff_cycles on entry; decrement each cycle; go to IDLE when it reaches 1. Gap is exactly holdoff_cycles cycles.
- Latency: ext_trig in cycle N with queue empty, state IDLE and enable=1 gives tm_trigger in cycle N+2.
- tm_done outside WAIT_DONE is ignored.
- enable deassert mid-operation: the in-flight fill completes normally; queued entries are retained and issued after re-enable.
- tm_fill_type keeps its last value after completion; it is only reloaded in ISSUE.
- pending_count and busy are registered and update the cycle after the event.

Optional Feature:
TRIG_TIMEOUT_EN
- Defined: a watchdog counts cycles in WAIT_DONE. On reaching TIMEOUT_CYC, set timeout_err (sticky) and go to HOLDOFF as if done.
- Undefined: no watchdog logic; WAIT_DONE waits indefinitely; timeout_err tied to 0.

Decomposition:
- Shared package: fill-type encoding constants (2-bit), FSM state encoding, default CNT_W.
- Sub-module: trig_fill_fifo, the DEPTH-entry synchronous FIFO with push/pop/count. The FSM, holdoff, watchdog and stats stay in trigger_scheduler.

Test Plan:
- Single trigger: holdoff_cycles=0, ext_trig with fill_type=2 at cycle 10 -> tm_trigger at cycle 12 only, tm_fill_type=2; tm_done at cycle 20 -> busy low at 21.
- Burst: DEPTH=4, 6 pulses in consecutive cycles while a fill is in flight -> 4 queued, drop_count=2; 4 issues in FIFO order with matching fill types.
- Holdoff: holdoff_cycles=5, two queued triggers -> second tm_trigger exactly 5+2 cycles after the tm_done that ends the first.
- Enable gating: enable=0 with 2 queued entries -> no issue and new pulses ignored (drop_count unchanged); enable=1 -> issues resume.
- Reset: reset_n low during WAIT_DONE -> all outputs 0 immediately; queue empty after release.
- With TRIG_TIMEOUT_EN: TIMEOUT_CYC=100, no tm_done -> timeout_err=1 after 100 cycles in WAIT_DONE, next entry issued; clear_stats -> timeout_err=0.
